// File: rtl/rhd_spi_responder_if.sv
// ---------------------------------------------------------------------------
// rhd_spi_responder_if
//
// The four-wire RHD2000 SPI bus between the acquisition master and one
// amplifier chip.
//
//   CS    chip select, active low          (master -> chip)
//   SCLK  serial clock, idles low          (master -> chip)
//   MOSI  command bits, MSB first          (master -> chip)
//   MISO  result bits, MSB first           (chip -> master)
//
// The master modport is used by whatever drives the bus (the SPI master IP or
// a testbench); the slave modport is used by the chip model.
// ---------------------------------------------------------------------------
interface rhd_spi_responder_if;
    logic CS;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (
        output CS,
        output SCLK,
        output MOSI,
        input  MISO
    );

    modport slave (
        input  CS,
        input  SCLK,
        input  MOSI,
        output MISO
    );
endinterface

// File: rtl/rhd_spi_responder.sv
// ---------------------------------------------------------------------------
// rhd_spi_responder
//
// Behavioural, synthesizable stand-in for the SPI slave side of one RHD2000
// amplifier chip. It lets the SPI master's MISO capture, delay compensation
// and data path be exercised without silicon. One instance per MOSI line.
//
// All bus inputs are oversampled in the aclk domain, so SCLK must be at most
// aclk/4.
//
// Command set (16-bit word, MSB first):
//   00CCCCCC_xxxxxxxx  CONVERT   -> {C, frame[9:0]}; frame++ when C == 0
//   10RRRRRR_DDDDDDDD  WRITE     -> {8'hFF, D}; reg[R] <= D when R <= 21
//   11RRRRRR_xxxxxxxx  READ      -> {8'h00, value of register R}
//   0x5500             CALIBRATE -> 0x0000
//   0x6A00             CLEAR     -> 0x0000; frame <= 0
//   other 01xxxxxx               -> 0xFFFF
// The result of a command is shifted out two frames later.
//
// Parameters:
//   CHIP_ID     value read back from register 63
//   DIE_REV     value read back from register 60
//   MISO_DELAY  extra aclk cycles on MISO (0..15), emulates cable round trip
//   SYNC_STAGES synchronizer depth on CS/SCLK/MOSI (2..3)
//
// Ports:
//   aclk       system clock, shared with the SPI master
//   aresetn    asynchronous active-low reset
//   spi        SPI bus, slave modport (CS, SCLK, MOSI in; MISO out)
//   cmd_count  number of complete 16-bit frames decoded, wraps at 0xFFFF
//   frame_err  one-cycle pulse when a frame ends with a bit count other
//              than 16
// ---------------------------------------------------------------------------
module rhd_spi_responder #(
    parameter logic [7:0]  CHIP_ID     = 8'd1,
    parameter logic [7:0]  DIE_REV     = 8'd1,
    parameter int unsigned MISO_DELAY  = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    rhd_spi_responder_if.slave        spi,
    output logic [15:0]               cmd_count,
    output logic                      frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_t;

    localparam logic [4:0] BIT_CNT_FULL = 5'd16;
    localparam logic [4:0] BIT_CNT_SAT  = 5'd17;
    localparam int         NUM_REGS     = 22;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detectors
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_prev_q,   cs_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;

    logic cs_s;
    logic sclk_s;
    logic mosi_s;
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;

    // MOSI goes through the same number of stages as SCLK so the bit seen
    // alongside a detected SCLK rise is the one the master set up for it.
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi.CS};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi.SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.MOSI};
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_s;
        sclk_prev_d = sclk_s;
        cs_fall     = cs_prev_q & ~cs_s;
        cs_rise     = ~cs_prev_q & cs_s;
        sclk_rise   = ~sclk_prev_q & sclk_s;
        sclk_fall   = sclk_prev_q & ~sclk_s;
    end

    // CS resets to its idle-high level so releasing reset with the bus idle
    // does not look like the start of a frame.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_prev_q   <= cs_prev_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // Chip state
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [4:0]  bit_cnt_q,   bit_cnt_d;
    logic [15:0] in_sr_q,     in_sr_d;
    logic [15:0] out_sr_q,    out_sr_d;
    logic [15:0] r1_q,        r1_d;
    logic [15:0] r2_q,        r2_d;
    logic [9:0]  frame_q,     frame_d;
    logic [15:0] cmd_count_q, cmd_count_d;
    logic        frame_err_q, frame_err_d;
    logic [7:0]  regs_q [0:NUM_REGS-1];
    logic [7:0]  regs_d [0:NUM_REGS-1];

    // ------------------------------------------------------------------
    // Command decode, evaluated on the completed input word
    // ------------------------------------------------------------------
    logic [5:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [7:0]  rd_val;
    logic [15:0] dec_result;
    logic [9:0]  dec_frame;
    logic        dec_wr_en;

    always_comb begin
        cmd_addr   = in_sr_q[13:8];
        cmd_data   = in_sr_q[7:0];
        dec_result = 16'h0000;
        dec_frame  = frame_q;
        dec_wr_en  = 1'b0;
        rd_val     = 8'h00;

        // Registers 40..44 spell "INTAN"; everything unmapped reads zero.
        if (cmd_addr <= 6'd21) begin
            rd_val = regs_q[cmd_addr[4:0]];
        end else begin
            case (cmd_addr)
                6'd40:   rd_val = 8'h49;
                6'd41:   rd_val = 8'h4E;
                6'd42:   rd_val = 8'h54;
                6'd43:   rd_val = 8'h41;
                6'd44:   rd_val = 8'h4E;
                6'd60:   rd_val = DIE_REV;
                6'd63:   rd_val = CHIP_ID;
                default: rd_val = 8'h00;
            endcase
        end

        case (in_sr_q[15:14])
            2'b00: begin
                // The frame counter only advances on channel 0, and only
                // after the current value has been captured in the result.
                dec_result = {cmd_addr, frame_q};
                if (cmd_addr == 6'd0) begin
                    dec_frame = frame_q + 10'd1;
                end
            end
            2'b10: begin
                // Writes to unimplemented registers still echo the data.
                dec_result = {8'hFF, cmd_data};
                dec_wr_en  = (cmd_addr <= 6'd21);
            end
            2'b11: begin
                dec_result = {8'h00, rd_val};
            end
            default: begin
                if (in_sr_q == 16'h5500) begin
                    dec_result = 16'h0000;
                end else if (in_sr_q == 16'h6A00) begin
                    dec_result = 16'h0000;
                    dec_frame  = 10'd0;
                end else begin
                    dec_result = 16'hFFFF;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        in_sr_d     = in_sr_q;
        out_sr_d    = out_sr_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        frame_d     = frame_q;
        cmd_count_d = cmd_count_q;
        frame_err_d = 1'b0;
        regs_d      = regs_q;

        unique case (state_q)
            ST_IDLE: begin
                // The word shifted out now is the result from two frames ago.
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    out_sr_d  = r2_q;
                    bit_cnt_d = 5'd0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    // Clearing out_sr keeps MISO low between frames, even
                    // after an aborted one.
                    out_sr_d = 16'h0000;
                    if (bit_cnt_q == BIT_CNT_FULL) begin
                        state_d = ST_DECODE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    // Saturating at 17 means over-long frames stay
                    // distinguishable from complete ones.
                    if (sclk_rise) begin
                        in_sr_d = {in_sr_q[14:0], mosi_s};
                        if (bit_cnt_q != BIT_CNT_SAT) begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                    if (sclk_fall) begin
                        out_sr_d = {out_sr_q[14:0], 1'b0};
                    end
                end
            end
            ST_DECODE: begin
                r2_d        = r1_q;
                r1_d        = dec_result;
                frame_d     = dec_frame;
                cmd_count_d = cmd_count_q + 16'd1;
                if (dec_wr_en) begin
                    regs_d[cmd_addr[4:0]] = cmd_data;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame FSM registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            in_sr_q     <= 16'h0000;
            out_sr_q    <= 16'h0000;
            r1_q        <= 16'h0000;
            r2_q        <= 16'h0000;
            frame_q     <= 10'd0;
            cmd_count_q <= 16'h0000;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            in_sr_q     <= in_sr_d;
            out_sr_q    <= out_sr_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            frame_q     <= frame_d;
            cmd_count_q <= cmd_count_d;
            frame_err_q <= frame_err_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign cmd_count = cmd_count_q;
    assign frame_err = frame_err_q;

    // ------------------------------------------------------------------
    // MISO output and optional cable-delay emulation
    // ------------------------------------------------------------------
    if (MISO_DELAY == 0) begin : g_no_delay
        assign spi.MISO = out_sr_q[15];
    end else begin : g_delay
        logic [MISO_DELAY-1:0] miso_dly_q, miso_dly_d;

        // Delay applies to MISO only; the FSM still reacts with the
        // undelayed synchronizer latency.
        always_comb begin
            miso_dly_d    = miso_dly_q << 1;
            miso_dly_d[0] = out_sr_q[15];
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                miso_dly_q <= '0;
            end else begin
                miso_dly_q <= miso_dly_d;
            end
        end

        assign spi.MISO = miso_dly_q[MISO_DELAY-1];
    end

endmodule

// File: tb/tb_rhd_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_rhd_spi_responder
//
// Acts as the RHD SPI master for one responder instance (with cable delay
// enabled). The driver sends frames and, for each complete frame, pushes the
// word the chip should return into a queue, using a register-level model of
// the chip. A monitor rebuilds MISO words by sampling a fixed latency after
// each SCLK rise and pops/compares on every completed frame.
// ---------------------------------------------------------------------------
module tb_rhd_spi_responder;

    localparam int         SYNC = 2;
    localparam int         DLY  = 3;
    localparam int         LAG  = SYNC + DLY;
    localparam logic [7:0] CHIP = 8'h04;
    localparam logic [7:0] DIE  = 8'h01;

    logic        aclk;
    logic        aresetn;
    logic [15:0] cmd_count;
    logic        frame_err;

    rhd_spi_responder_if spi_bus ();

    rhd_spi_responder #(
        .CHIP_ID    (CHIP),
        .DIE_REV    (DIE),
        .MISO_DELAY (DLY),
        .SYNC_STAGES(SYNC)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .spi      (spi_bus),
        .cmd_count(cmd_count),
        .frame_err(frame_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q [$];
    logic [15:0] pipe_q [$];
    logic [7:0]  m_regs [0:21];
    int          m_frame;
    int          m_cmd_count;
    int          exp_err  = 0;
    int          err_seen = 0;
    int          word_idx = 0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [1:0] k, input logic [5:0] a, input logic [7:0] d);
        return {k, a, d};
    endfunction

    // Chip model: registers, identification bytes and the frame counter.
    function automatic logic [7:0] model_read(input int addr);
        string intan;
        intan = "INTAN";
        if (addr < 22) return m_regs[addr];
        if (addr >= 40 && addr <= 44) return intan[addr - 40];
        if (addr == 60) return DIE;
        if (addr == 63) return CHIP;
        return 8'h00;
    endfunction

    function automatic logic [15:0] model_cmd(input logic [15:0] cmd);
        int kind;
        int addr;
        int data;
        int res;
        kind = int'(cmd[15:14]);
        addr = int'(cmd[13:8]);
        data = int'(cmd[7:0]);
        res  = 0;
        case (kind)
            0: begin
                res = addr * 1024 + m_frame;
                if (addr == 0) m_frame = (m_frame + 1) % 1024;
            end
            2: begin
                if (addr < 22) m_regs[addr] = 8'(data);
                res = 'hFF00 + data;
            end
            3: res = int'(model_read(addr));
            default: begin
                if (cmd == 16'h5500) res = 0;
                else if (cmd == 16'h6A00) begin
                    res     = 0;
                    m_frame = 0;
                end else res = 'hFFFF;
            end
        endcase
        return 16'(res);
    endfunction

    task automatic model_reset();
        pipe_q.delete();
        pipe_q.push_back(16'h0000);
        pipe_q.push_back(16'h0000);
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_frame     = 0;
        m_cmd_count = 0;
    endtask

    task automatic mid_frame_reset();
        aresetn      = 1'b0;
        spi_bus.CS   = 1'b1;
        spi_bus.SCLK = 1'b0;
        spi_bus.MOSI = 1'b0;
        repeat (3) @(negedge aclk);
        checkOutput("midreset_miso", 32'(spi_bus.MISO), 32'h0);
        checkOutput("midreset_cmd_count", 32'(cmd_count), 32'h0);
        checkOutput("midreset_frame_err", 32'(frame_err), 32'h0);
        aresetn = 1'b1;
        model_reset();
        repeat (LAG + 4) @(negedge aclk);
    endtask

    // Sends one frame of nbits SCLK pulses; rst_at >= 0 asserts reset just
    // before that pulse instead of finishing the frame.
    task automatic applyStimulus(input logic [15:0] cmd, input int nbits, input int rst_at);
        logic [15:0] res;
        @(negedge aclk);
        spi_bus.CS = 1'b0;
        repeat ($urandom_range(3, 2)) @(negedge aclk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                mid_frame_reset();
                return;
            end
            spi_bus.MOSI = (i < 16) ? cmd[15 - i] : 1'($urandom);
            repeat ($urandom_range(4, 2)) @(negedge aclk);
            spi_bus.SCLK = 1'b1;
            repeat ($urandom_range(4, 2)) @(negedge aclk);
            spi_bus.SCLK = 1'b0;
        end
        repeat ($urandom_range(3, 2)) @(negedge aclk);
        if (nbits == 16) begin
            exp_q.push_back(pipe_q.pop_front());
            res = model_cmd(cmd);
            pipe_q.push_back(res);
            m_cmd_count++;
        end else begin
            exp_err++;
        end
        spi_bus.CS   = 1'b1;
        spi_bus.MOSI = 1'b0;
        repeat ($urandom_range(5, 3)) @(negedge aclk);
    endtask

    task automatic checkCounts(input string tag);
        repeat (LAG + 6) @(negedge aclk);
        checkOutput({tag, "_cmd_count"}, 32'(cmd_count), 32'(16'(m_cmd_count)));
        checkOutput({tag, "_frame_err_cycles"}, 32'(err_seen), 32'(exp_err));
        checkOutput({tag, "_pending_words"}, 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: looks at the bus through the chip's known latency.
    initial begin
        logic [LAG+1:0] sclk_h;
        logic [LAG+1:0] cs_h;
        logic [15:0]    word;
        int             nbits;
        sclk_h = '0;
        cs_h   = '1;
        word   = 16'h0000;
        nbits  = 0;
        forever begin
            @(posedge aclk);
            sclk_h = {sclk_h[LAG:0], spi_bus.SCLK};
            cs_h   = {cs_h[LAG:0], spi_bus.CS};
            #1;
            if (frame_err === 1'b1) err_seen++;
            if (!cs_h[LAG] && cs_h[LAG+1]) begin
                word  = 16'h0000;
                nbits = 0;
            end
            if (sclk_h[LAG] && !sclk_h[LAG+1] && !cs_h[LAG]) begin
                word = {word[14:0], spi_bus.MISO};
                nbits++;
            end
            if (cs_h[LAG] && !cs_h[LAG+1] && nbits == 16) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL miso_word%0d: got 0x%0h, expected no frame", word_idx, word);
                end else begin
                    checkOutput($sformatf("miso_word%0d", word_idx), 32'(word), 32'(exp_q.pop_front()));
                end
                word_idx++;
            end
        end
    end

    initial begin
        repeat (90000) @(posedge aclk);
        failures++;
        $display("[TB] FAIL watchdog: simulation did not complete within 90000 cycles");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] cmd;
        int          r;
        int          nb;
        spi_bus.CS   = 1'b1;
        spi_bus.SCLK = 1'b0;
        spi_bus.MOSI = 1'b0;
        aresetn      = 1'b0;
        model_reset();
        repeat (4) @(negedge aclk);
        checkOutput("reset_miso", 32'(spi_bus.MISO), 32'h0);
        checkOutput("reset_cmd_count", 32'(cmd_count), 32'h0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);

        $display("[TB] INTAN readback");
        for (int a = 40; a <= 44; a++) applyStimulus(mk(2'b11, 6'(a), 8'h00), 16, -1);
        repeat (2) applyStimulus(mk(2'b11, 6'd63, 8'h00), 16, -1);
        checkCounts("intan");

        $display("[TB] register write/read");
        applyStimulus(mk(2'b10, 6'd5, 8'hA3), 16, -1);
        applyStimulus(mk(2'b11, 6'd5, 8'h00), 16, -1);
        applyStimulus(mk(2'b10, 6'd30, 8'h11), 16, -1);
        applyStimulus(mk(2'b11, 6'd30, 8'h00), 16, -1);
        applyStimulus(mk(2'b11, 6'd60, 8'h00), 16, -1);
        repeat (2) applyStimulus(mk(2'b11, 6'd63, 8'h00), 16, -1);
        checkCounts("regs");

        $display("[TB] convert sweep, clear, calibrate");
        for (int p = 0; p < 3; p++)
            for (int ch = 0; ch < 32; ch++) applyStimulus(mk(2'b00, 6'(ch), 8'h00), 16, -1);
        applyStimulus(16'h6A00, 16, -1);
        applyStimulus(mk(2'b00, 6'd0, 8'h00), 16, -1);
        applyStimulus(16'h5500, 16, -1);
        applyStimulus(16'h4123, 16, -1);
        repeat (2) applyStimulus(mk(2'b00, 6'd0, 8'h00), 16, -1);
        checkCounts("convert");

        $display("[TB] aborted frames");
        applyStimulus(mk(2'b11, 6'd41, 8'h00), 10, -1);
        applyStimulus(mk(2'b11, 6'd42, 8'h00), 16, -1);
        applyStimulus(mk(2'b11, 6'd43, 8'h00), 17, -1);
        applyStimulus(mk(2'b11, 6'd44, 8'h00), 0, -1);
        repeat (2) applyStimulus(mk(2'b11, 6'd63, 8'h00), 16, -1);
        checkCounts("abort");

        $display("[TB] random traffic");
        for (int n = 0; n < 120; n++) begin
            r = int'($urandom_range(99, 0));
            case ($urandom_range(3, 0))
                0:       cmd = mk(2'b00, 6'($urandom_range(33, 0)), 8'($urandom));
                1:       cmd = mk(2'b10, 6'($urandom_range(31, 0)), 8'($urandom));
                2:       cmd = mk(2'b11, 6'($urandom_range(63, 0)), 8'($urandom));
                default: begin
                    case ($urandom_range(2, 0))
                        0:       cmd = 16'h5500;
                        1:       cmd = 16'h6A00;
                        default: cmd = mk(2'b01, 6'($urandom), 8'($urandom));
                    endcase
                end
            endcase
            if (r < 10) begin
                nb = int'($urandom_range(17, 0));
                if (nb == 16) nb = 17;
                applyStimulus(cmd, nb, -1);
            end else begin
                applyStimulus(cmd, 16, -1);
            end
        end
        checkCounts("random");

        $display("[TB] reset in the middle of a frame");
        applyStimulus(mk(2'b11, 6'd40, 8'h00), 16, 7);
        applyStimulus(mk(2'b11, 6'd40, 8'h00), 16, -1);
        applyStimulus(mk(2'b11, 6'd63, 8'h00), 16, -1);
        applyStimulus(mk(2'b00, 6'd0, 8'h00), 16, -1);
        applyStimulus(mk(2'b00, 6'd0, 8'h00), 16, -1);
        checkCounts("postreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
